// File: rtl/bitwise_accum.sv
// rtl/bitwise_accum.sv - streaming bitwise reduction of a word packet
//
// Folds a packet of WIDTH-bit words into one result word with a per-packet
// bitwise operation (AND / OR / XOR / PASS, optional final inversion). It also
// reports a saturating word count. Both sides use a valid/ready handshake.
//
// Ports:
//   clock      - single clock, all state updates on rising edge
//   reset      - synchronous, active-high
//   in_valid   - input word present
//   in_ready   - unit can accept a word this cycle
//   in_data    - input word
//   in_last    - marks the final word of a packet
//   op         - [1:0] 00 AND, 01 OR, 10 XOR, 11 PASS; [2] invert result.
//                Sampled only on a packet's first beat.
//   out_valid  - result available (held until out_ready)
//   out_ready  - consumer accepts result
//   out_data   - reduced result
//   out_count  - words in packet, saturating at all-ones

module bitwise_accum #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]     acc_d;
  logic [COUNT_W-1:0]   cnt_q;
  logic [COUNT_W-1:0]   cnt_d;
  logic [2:0]           op_q;
  logic [2:0]           op_eff;
  logic [WIDTH-1:0]     res_d;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [COUNT_W-1:0]   out_count_q;
  logic                 beat;

  // Gated by reset so no beat is ever seen as accepted during reset.
  assign in_ready  = !reset && (state_q != S_DONE);
  assign beat      = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  // Next accumulator/count for the beat being offered. On the first beat the
  // live op input is used (it is being captured this cycle); afterwards the
  // captured op_q is used so later op changes are ignored.
  always_comb begin
    op_eff = (state_q == S_IDLE) ? op : op_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    if (state_q == S_IDLE) begin
      acc_d = in_data;
      cnt_d = COUNT_W'(1);
    end else begin
      unique case (op_q[1:0])
        2'b00:   acc_d = acc_q & in_data;
        2'b01:   acc_d = acc_q | in_data;
        2'b10:   acc_d = acc_q ^ in_data;
        default: acc_d = in_data;
      endcase
      cnt_d = (cnt_q == {COUNT_W{1'b1}}) ? cnt_q : cnt_q + COUNT_W'(1);
    end
    // Inversion is applied once, to the final result only.
    res_d = op_eff[2] ? ~acc_d : acc_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_ACC: begin
          if (beat) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (state_q == S_IDLE) begin
              op_q <= op;
            end
            if (in_last) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= res_d;
              out_count_q <= cnt_d;
            end else begin
              state_q <= S_ACC;
            end
          end
        end
        S_DONE: begin
          // Result registers stay untouched here, so they are stable while
          // out_valid is high.
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bitwise_accum.md
# bitwise_accum

Parametrised streaming bitwise reduction unit: the sequential successor to the fixed 16-bit And16/Or16/Not16 word gates. It accepts a packet of WIDTH-bit words over a valid/ready handshake and folds them into an accumulator with a per-packet bitwise operation (AND, OR, XOR or pass, with optional final inversion). It presents one result word plus a saturating word count on a valid/ready output port. It sits between a word source (memory scan, register file dump) and a consumer such as the ALU path or a flag/compare stage.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- COUNT_W, 8, width of the word counter (≥1)
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  unit can accept a word this cycle
- in_data  input  WIDTH  input word
- in_last  input  1  qualifies the final word of a packet
- op  input  3  op[1:0]: 00 AND, 01 OR, 10 XOR, 11 PASS; op[2]: invert final result. Sampled only on a packet's first beat.
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  reduced result
- out_count  output  COUNT_W  words in packet, saturating at 2^COUNT_W−1

## Operation
- Beat accepted when in_valid && in_ready in the same cycle.
- States:
  - IDLE → first beat: acc ← in_data, op_r ← op, cnt ← 1. If in_last, go to DONE; else go to ACC.
  - ACC → each beat: acc ← f(acc, in_data), cnt ← sat(cnt+1). If in_last, go to DONE.
  - DONE → out_valid=1. When out_ready, go to IDLE.
- f by op_r[1:0]:
  - AND: acc & in
  - OR: acc | in
  - XOR: acc ^ in
  - PASS: in (last word wins)
- Load rule is identical for all ops: the first word is loaded unmodified.
- Inversion applies only once, at the result: out_data = op_r[2] ? ~acc : acc. Ops 100/101/110 therefore yield NAND/NOR/XNOR reductions.
- Bitwise only; no carries, no width growth.
- Counter saturates: once at 2^COUNT_W−1 it holds, and no wrap to 0 is permitted.
- in_ready = !reset && state != DONE. No input beat is accepted while a result is pending.
- op changes after the first beat are ignored until the next packet.
- in_valid low in IDLE/ACC: state and acc hold; gaps between beats are allowed.
- Words are written into out_data/out_count registers on the DONE transition. Both are stable for the whole time out_valid=1.

## Timing
- Reset (synchronous): state=IDLE, out_valid=0, out_data=0, out_count=0, acc=0, cnt=0, op_r=0.
  - in_ready=0 while reset is high and 1 the first cycle after.
- Reset mid-packet discards the partial accumulation; no output is produced for it.
- Latency: out_valid rises the cycle after the in_last beat is accepted.
- Output handshake: the result is consumed on the edge where out_valid && out_ready. out_valid falls the next cycle, and in_ready rises in that same cycle.
- Throughput: an N-word packet with out_ready held high occupies N+1 cycles (N accept cycles + 1 DONE cycle). The next packet's first beat is accepted in the cycle after the DONE handshake.
- Single-word packet (in_last on first beat): goes IDLE → DONE directly, with out_count=1.
- out_ready high while out_valid=0 has no effect.
- out_valid never drops without a handshake, except on reset.

## Test plan
- WIDTH=16, op=000, words 0xFFFF, 0x0F0F, 0x00FF (last) on consecutive cycles → one cycle after last beat: out_valid=1, out_data=0x000F, out_count=3.
- op=101 (NOR), words 0x1200, 0x0034 (last), op driven to 000 on the 2nd beat → out_data=0xEDCB (op change ignored), out_count=2.
- op=010, single word 0xA5A5 with in_last → out_valid next cycle, out_data=0xA5A5, out_count=1. Then a back-to-back packet is accepted the cycle after the handshake.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_data/out_count stable, in_ready=0, offered in_valid beats not consumed. Raise out_ready → handshake, then in_ready=1 next cycle.
- COUNT_W=4, op=011, 20 words 0x0001..0x0014 (last) → out_count=15 (saturated), out_data=0x0014.
- Reset asserted after 2 beats of an AND packet, then new packet op=001: 0x0F00, 0x00F0 (last) → out_data=0x0FF0, out_count=2. No output for the aborted packet; all outputs 0 during reset.
